// File: rtl/regfile_param.sv
// Parametrised register file: DEPTH x DATA_W storage, two combinational read ports plus a debug port.
// Latency: reads are combinational; writes commit at the rising edge and can be forwarded in the same cycle.
// Backpressure: while the clear sweep is running, writes are dropped and flagged on wr_err one cycle later.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_sweep;
  logic              sweep_last;
  logic              wr_acc;

  // Register 0 is only special when the build hardwires it to zero.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // FSM state and sweep pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state logic: clr_req only matters in IDLE; the sweep runs DEPTH cycles then returns.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_SWEEP;
          clr_ptr_d = '0;
        end
      end
      ST_SWEEP: begin
        // Pointer wraps back to 0 naturally after the last entry.
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  // FSM outputs: write acceptance, busy, and next values of the registered pulses.
  always_comb begin
    in_sweep   = (state_q == ST_SWEEP);
    sweep_last = in_sweep && (clr_ptr_q == LAST_PTR);
    wr_acc     = wr_en && !in_sweep && !is_zero_reg(wr_addr);
    clr_done_d = sweep_last;
    // Any write request seen mid-sweep is dropped, including one aimed at register 0.
    wr_err_d   = wr_en && in_sweep;
  end

  // Registered one-cycle status pulses; reset suppresses a pending clr_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      clr_done_q <= clr_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Storage update: sweep clears one entry per cycle; otherwise an accepted write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (in_sweep) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port 1: zero register, then same-cycle forwarding, then storage.
  always_comb begin
    if (is_zero_reg(rd_addr1)) begin
      rd_data1 = '0;
    end else if ((BYPASS != 0) && wr_acc && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = mem_q[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    if (is_zero_reg(rd_addr2)) begin
      rd_data2 = '0;
    end else if ((BYPASS != 0) && wr_acc && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = mem_q[rd_addr2];
    end
  end

  // Debug port shows committed storage only, never the in-flight write.
  always_comb begin
    if (is_zero_reg(dbg_addr)) begin
      dbg_data = '0;
    end else begin
      dbg_data = mem_q[dbg_addr];
    end
  end

  assign clr_busy = in_sweep;
  assign clr_done = clr_done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default build and a build without zero register or forwarding.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well before the next rising edge.
// Every wait on a DUT event is bounded and a timeout counts as a failure.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
  logic [31:0] wr_data;
  logic        wr_en, clr_req;

  logic [31:0] rd_data1, rd_data2, dbg_data;
  logic        clr_busy, clr_done, wr_err;
  logic [31:0] nz_rd_data1, nz_rd_data2, nz_dbg_data;
  logic        nz_clr_busy, nz_clr_done, nz_wr_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_err(wr_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_nz (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(nz_rd_data1), .rd_data2(nz_rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(nz_clr_busy), .clr_done(nz_clr_done), .wr_err(nz_wr_err),
    .dbg_addr(dbg_addr), .dbg_data(nz_dbg_data)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_one(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Waits at most 'limit' cycles for clr_done; leaves time at negedge+1 of the pulse cycle.
  task automatic wait_done(input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      #1;
      if (clr_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_FFFF; clr_req = 1'b1;
    step(); step();
    rst = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    rd_addr1 = 5'd4; rd_addr2 = 5'd9; dbg_addr = 5'd4;
    #1;
    checks++; if (rd_data1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=0", rd_data1); end
    checks++; if (rd_data2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=0", rd_data2); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
    checks++; if (nz_rd_data1 !== 32'h0) begin failures++; $display("FAIL reset_nz_rd1 got=%h exp=0", nz_rd_data1); end
    checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", clr_done); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
    step();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr1 = 5'd5; dbg_addr = 5'd5;
    #1;
    checks++; if (rd_data1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rd1 got=%h exp=deadbeef", rd_data1); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL bypass_dbg_same_cycle got=%h exp=0", dbg_data); end
    checks++; if (nz_rd_data1 !== 32'h0) begin failures++; $display("FAIL nobypass_rd1 got=%h exp=0", nz_rd_data1); end
    step();
    wr_en = 1'b0;
    #1;
    checks++; if (dbg_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_dbg_next got=%h exp=deadbeef", dbg_data); end
    checks++; if (nz_rd_data1 !== 32'hDEADBEEF) begin failures++; $display("FAIL nobypass_rd1_next got=%h exp=deadbeef", nz_rd_data1); end
    step();
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr2 = 5'd0;
    #1;
    checks++; if (rd_data2 !== 32'h0) begin failures++; $display("FAIL zero_rd2_same got=%h exp=0", rd_data2); end
    checks++; if (nz_rd_data2 !== 32'h0) begin failures++; $display("FAIL nz_r0_same got=%h exp=0", nz_rd_data2); end
    step();
    wr_en = 1'b0;
    #1;
    checks++; if (rd_data2 !== 32'h0) begin failures++; $display("FAIL zero_rd2_next got=%h exp=0", rd_data2); end
    checks++; if (nz_rd_data2 !== 32'h12345678) begin failures++; $display("FAIL nz_r0_next got=%h exp=12345678", nz_rd_data2); end
    step();
  endtask

  task automatic test_sweep();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    int bad      = 0;
    for (int i = 0; i < 32; i++) write_one(i[4:0], i);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    rd_addr1 = 5'd3; rd_addr2 = 5'd20;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (c == 10) begin
        checks++; if (rd_data1 !== 32'h0) begin failures++; $display("FAIL sweep_mid_r3 got=%h exp=0", rd_data1); end
        checks++; if (rd_data2 !== 32'd20) begin failures++; $display("FAIL sweep_mid_r20 got=%h exp=14", rd_data2); end
        checks++; if (nz_rd_data2 !== 32'd20) begin failures++; $display("FAIL sweep_mid_nz_r20 got=%h exp=14", nz_rd_data2); end
      end
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; done_at = c; end
      step();
    end
    checks++; if (busy_cnt != 32) begin failures++; $display("FAIL sweep_busy_cycles got=%0d exp=32", busy_cnt); end
    checks++; if (done_at != 33) begin failures++; $display("FAIL sweep_done_cycle got=%0d exp=33", done_at); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL sweep_done_pulses got=%0d exp=1", done_cnt); end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      if (dbg_data !== 32'h0 || nz_dbg_data !== 32'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL sweep_all_zero nonzero_entries=%0d exp=0", bad); end
    step();
  endtask

  task automatic test_write_drop();
    logic found;
    write_one(5'd7, 32'h11);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA; rd_addr1 = 5'd7; dbg_addr = 5'd7;
    #1;
    checks++; if (rd_data1 !== 32'h11) begin failures++; $display("FAIL drop_no_bypass got=%h exp=11", rd_data1); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL drop_err_early got=%b exp=0", wr_err); end
    step();
    wr_en = 1'b0;
    #1;
    checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL drop_err_pulse got=%b exp=1", wr_err); end
    checks++; if (dbg_data !== 32'h11) begin failures++; $display("FAIL drop_r7_kept got=%h exp=11", dbg_data); end
    step();
    #1;
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL drop_err_one_cycle got=%b exp=0", wr_err); end
    step();
    wait_done(40, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL drop_done_timeout got=%b exp=1", found); end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rd_addr1 = 5'd9; dbg_addr = 5'd9;
    #1;
    checks++; if (rd_data1 !== 32'h99) begin failures++; $display("FAIL done_cycle_write_bypass got=%h exp=99", rd_data1); end
    step();
    wr_en = 1'b0;
    #1;
    checks++; if (dbg_data !== 32'h99) begin failures++; $display("FAIL done_cycle_write_stored got=%h exp=99", dbg_data); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL done_cycle_write_err got=%b exp=0", wr_err); end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int bad = 0;
    int done_cnt = 0;
    write_one(5'd12, 32'hC);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL rst_sweep_busy got=%b exp=0", clr_busy); end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      if (dbg_data !== 32'h0 || nz_dbg_data !== 32'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_sweep_all_zero nonzero_entries=%0d exp=0", bad); end
    step();
    for (int c = 0; c < 40; c++) begin
      #1;
      if (clr_done === 1'b1) done_cnt++;
      step();
    end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rst_sweep_no_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_clr_with_write();
    int bad = 0;
    logic found;
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h55;
    step();
    clr_req = 1'b0; wr_en = 1'b0; dbg_addr = 5'd31;
    for (int c = 1; c <= 32; c++) begin
      #1;
      if (c <= 31 && dbg_data !== 32'h55) bad++;
      step();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL clrwr_r31_held bad_cycles=%0d exp=0", bad); end
    #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL clrwr_r31_cleared got=%h exp=0", dbg_data); end
    checks++; if (clr_done !== 1'b1) begin failures++; $display("FAIL clrwr_done got=%b exp=1", clr_done); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b1) begin failures++; $display("FAIL back_to_back_busy got=%b exp=1", clr_busy); end
    step();
    wait_done(40, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL back_to_back_done_timeout got=%b exp=1", found); end
    step();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; dbg_addr = '0; wr_data = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_sweep();
    test_write_drop();
    test_reset_mid_sweep();
    test_clr_with_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the KGP-RISC datapath. It succeeds the fixed 32x32 register file. It provides:
- configurable data width and depth;
- an optional hardwired-zero register 0;
- optional same-cycle write-to-read forwarding;
- a sequenced background clear engine with a busy/done handshake;
- a debug read port replacing the fixed per-register taps.

It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1: an accepted write is forwarded to a matching read port in the same cycle

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data (combinational)
- rd_data2  out  DATA_W  read port 2 data (combinational)
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  start background clear of all entries (level sampled)
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse after the sweep completes
- wr_err  out  1  registered pulse: previous-cycle write was dropped because a sweep was active
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (combinational, no bypass)

## Operation
- **Storage:** DEPTH x DATA_W flops.
- **Accepted write:** wr_en=1 and FSM in IDLE and not (ZERO_REG=1 and wr_addr=0). An accepted write updates the entry at the rising edge.
- **Reads:**
  - rd_dataN = 0 if ZERO_REG=1 and rd_addrN=0.
  - Otherwise, if BYPASS=1 and the write is accepted and wr_addr=rd_addrN, rd_dataN = wr_data.
  - Otherwise rd_dataN = stored entry.
  - dbg_data follows the same zero rule but never bypasses.
- **FSM states:**
  - IDLE: clr_busy=0. clr_req=1 moves to SWEEP with clr_ptr=0. A write accepted in that same cycle is committed, and is then cleared by the sweep.
  - SWEEP: clr_busy=1. Each cycle, entry[clr_ptr] <= 0 and clr_ptr increments. When clr_ptr=DEPTH-1, that entry is cleared, state returns to IDLE, and clr_done=1 in the next cycle. clr_ptr is ADDR_W wide and wraps naturally to 0. clr_req is ignored in SWEEP.
- **Writes during SWEEP:** always dropped, with no storage change. wr_err is asserted for exactly one cycle, in the cycle after each dropped write. A dropped write is never forwarded.
- **Reads during SWEEP:** return current storage. Already-cleared entries read 0; not-yet-cleared entries read their old values.
- **Reset:**
  - All entries become 0, state IDLE, clr_ptr=0, and clr_busy, clr_done, wr_err all 0.
  - Reset overrides everything, including a write or clr_req in the same cycle.
  - Reset during SWEEP aborts the sweep with no clr_done.
- **Width rules:**
  - Addresses are compared at the full ADDR_W width.
  - No out-of-range addresses exist.
  - wr_data is stored unmodified.

## Timing
- Write latency: stored value is visible one cycle after the accepted write, or in the same cycle via BYPASS.
- Read latency: 0 cycles (combinational).
- Clear: clr_busy rises the cycle after clr_req is sampled in IDLE and stays high for exactly DEPTH cycles. clr_done pulses in the cycle after clr_busy falls, which is DEPTH+1 cycles after clr_req.
- Earliest accepted write after a sweep is in the clr_done cycle.
- Back-to-back clr_req: a new sweep can start in the clr_done cycle.
- Outputs after reset: rd_data1, rd_data2 and dbg_data are 0 for any address. clr_busy, clr_done and wr_err are 0.

## Test plan
- Reset, then write 0xDEADBEEF to r5 -> same cycle rd_data1 (rd_addr1=5) = 0xDEADBEEF via bypass; next cycle dbg_data (dbg_addr=5) = 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to r0 -> rd_data2 (addr 0) = 0 in the same cycle and forever after. ZERO_REG=0 build: r0 reads 0x12345678 next cycle.
- Fill r0..r31 with their index, then pulse clr_req -> clr_busy high for 32 cycles. Mid-sweep, r3 reads 0 and r20 reads 20. clr_done pulses at cycle 33; afterwards every entry reads 0.
- wr_en to r7 with 0xAA during a sweep -> r7 unchanged, no bypass, wr_err=1 in the next cycle only.
- rst asserted at sweep cycle 10 -> next cycle clr_busy=0, all entries 0, no clr_done pulse.
- clr_req and a write of 0x55 to r31 in the same IDLE cycle -> r31=0x55 for 31 sweep cycles, then 0 when clr_ptr=31.
